cnn_layer_sequencer: RTL
========================

CNN_LAYER_SEQUENCER -- requirements
Module: cnn_layer_sequencer

Interface
REQ-001 Parameter N_LAYER, default 3: layer-table depth, legal 1..16.
REQ-002 Parameter TI / TO / NDIV, defaults 16/16/16: weight stride per 3x3 layer = TI*TO*9/NDIV (144), per 1x1 layer = TO (16); param stride = TO for both layer types.
REQ-003 Parameter GAP_CYCLES, default 128: idle cycles between one layer's done and the next layer's load.
REQ-004 Parameter TIMEOUT_CYCLES, default 2^24-1: watchdog limit, used only with the Configuration macro.
REQ-005 HCLK  in  1  single clock, rising edge.
REQ-006 HRESETn  in  1  asynchronous, active-low reset.
REQ-007 cfg_we  in  1; cfg_idx  in  4; cfg_data  in  9 = {act_shift[2:0], bias_shift[4:0], is_conv3x3}: layer-table write port.
REQ-008 num_layers  in  5: layers per run; values above N_LAYER clamp to N_LAYER.
REQ-009 base_init  in  32 = {param[11:0], weight[19:0]}: first-layer base address, sampled at start.
REQ-010 start  in  1, abort  in  1: control pulses.
REQ-011 layer_done  in  1: accelerator done level, cleared by the accelerator on layer_start.
REQ-012 layer_start  out  1; layer_config  out  32; base_addr  out  32: accelerator programming.
REQ-013 busy  out  1; cur_layer  out  4; all_done  out  1 (one-cycle pulse); err  out  1 (sticky).

Function
REQ-014 Table write occurs when cfg_we=1, busy=0 and cfg_idx<N_LAYER; otherwise it is ignored.
REQ-015 FSM states: IDLE, LOAD, START, WAIT, GAP, NEXT, DONE.
REQ-016 IDLE->LOAD on start=1 with num_layers!=0; start is ignored when num_layers=0 or busy=1.
REQ-017 On the start edge, capture base_init and clamped num_layers, and set cur_layer=0.
REQ-018 LAYER_CONFIG FORMAT: LOAD drives layer_config = {16'b0, act_shift, bias_shift, cur_layer, is_last, is_conv3x3, is_last, is_first}.
REQ-019 is_first = (cur_layer==0); is_last = (cur_layer==num_layers-1).
REQ-020 LOAD drives base_addr from the current bases; both outputs hold until the next LOAD.
REQ-021 START asserts layer_start for exactly 1 cycle, exactly 1 cycle after LOAD.
REQ-022 WAIT advances to GAP on a rising edge of registered layer_done; a level already high on WAIT entry is ignored.
REQ-023 GAP counts GAP_CYCLES cycles; GAP_CYCLES=0 skips directly to NEXT.
REQ-024 NEXT: weight += 144 if is_conv3x3 else 16; param += 16; both wrap modulo field width (20 b / 12 b).
REQ-025 NEXT then increments cur_layer and goes to LOAD, or goes to DONE if the finished layer was last.
REQ-026 DONE pulses all_done for 1 cycle, then returns to IDLE.
REQ-027 busy=1 in every state except IDLE.
REQ-028 abort=1 in any state -> IDLE next cycle; no all_done; outputs keep their last values; abort has priority over start and layer_done in the same cycle.
REQ-029 err clears on an accepted start.

Reset
REQ-030 HRESETn low: state=IDLE; all outputs 0; bases, counters, captured num_layers and edge register 0; layer table all zeros. Effective asynchronously mid-run; no pending operation resumes after release.

Configuration
REQ-031 Macro LAYER_SEQ_TIMEOUT_EN defined: WAIT counts cycles; reaching TIMEOUT_CYCLES without a done edge sets err=1 and goes to IDLE without all_done.
REQ-032 LAYER_SEQ_TIMEOUT_EN undefined: no counter, WAIT waits indefinitely, err is tied to 0.

Verification
REQ-033 Table {bias,act,conv} = {9,7,0},{17,7,1},{17,7,1}, num_layers=3, base_init=0, done returned 50 cycles after each layer_start -> layer_config 0xE901, 0xF114, 0xF12E; base_addr 0x00000000, 0x01000010, 0x020000A0; one all_done pulse.
REQ-034 Single layer, num_layers=1, table {17,7,1} -> layer_config 0x0000F10F; one layer_start; all_done follows the done edge by GAP_CYCLES+2 cycles.
REQ-035 abort asserted in the same cycle as the layer-2 done edge -> IDLE next cycle, busy=0, no all_done; a new start reruns from layer 0 with base_init.
REQ-036 start held during a run, plus cfg_we while busy -> no restart; table contents unchanged.
REQ-037 layer_done held high before start -> first layer still waits for a fresh done edge.
REQ-038 With LAYER_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, done never returned -> err=1 at cycle 100 of WAIT, busy=0, no all_done.

Source files
------------

// File: rtl/cnn_layer_sequencer.sv
// cnn_layer_sequencer: walks a layer table and programs the CNN accelerator.
// Optional WAIT watchdog enabled by defining LAYER_SEQ_TIMEOUT_EN.
module cnn_layer_sequencer #(
  parameter int N_LAYER        = 3,
  parameter int TI             = 16,
  parameter int TO             = 16,
  parameter int NDIV           = 16,
  parameter int GAP_CYCLES     = 128,
  parameter int TIMEOUT_CYCLES = 24'hFF_FFFF
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_idx,
  input  logic [8:0]  cfg_data,
  input  logic [4:0]  num_layers,
  input  logic [31:0] base_init,
  input  logic        start,
  input  logic        abort,
  input  logic        layer_done,
  output logic        layer_start,
  output logic [31:0] layer_config,
  output logic [31:0] base_addr,
  output logic        busy,
  output logic [3:0]  cur_layer,
  output logic        all_done,
  output logic        err
);

  localparam logic [19:0] W3 = 20'(TI * TO * 9 / NDIV);
  localparam logic [19:0] W1 = 20'(TO);
  localparam logic [11:0] PS = 12'(TO);
  localparam logic [4:0] NMAX = 5'(N_LAYER);
  localparam int GW =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GLAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT, GAP, NEXT, DONE
  } state_t;

  state_t        state;
  logic [8:0]    tbl [16];
  logic [19:0]   w_base;
  logic [11:0]   p_base;
  logic [4:0]    n_lay;
  logic [GW-1:0] gap_cnt;
  logic          done_q;

  logic [8:0] ent;
  logic [4:0] nl_clamp;
  logic       tbl_we;
  logic       is_first;
  logic       is_last;
  logic       done_edge;

`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam logic [23:0] TLAST = 24'(TIMEOUT_CYCLES - 1);
  logic [23:0] wait_cnt;
  logic        err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy      = (state != IDLE);
  assign ent       = tbl[cur_layer];
  assign is_first  = (cur_layer == 4'd0);
  assign is_last   = ({1'b0, cur_layer} == n_lay - 5'd1);
  assign done_edge = layer_done & ~done_q;
  assign tbl_we    = cfg_we && !busy
                     && ({1'b0, cfg_idx} < NMAX);
  assign nl_clamp  = (num_layers > NMAX) ? NMAX
                                         : num_layers;

  // entries at or above N_LAYER are never written
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < 16; i++) tbl[i] <= '0;
    end else if (tbl_we) begin
      tbl[cfg_idx] <= cfg_data;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state        <= IDLE;
      w_base       <= '0;
      p_base       <= '0;
      n_lay        <= '0;
      gap_cnt      <= '0;
      done_q       <= 1'b0;
      cur_layer    <= '0;
      layer_start  <= 1'b0;
      layer_config <= '0;
      base_addr    <= '0;
      all_done     <= 1'b0;
`ifdef LAYER_SEQ_TIMEOUT_EN
      wait_cnt     <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      done_q      <= layer_done;
      layer_start <= 1'b0;
      all_done    <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && num_layers != 5'd0) begin
              state     <= LOAD;
              w_base    <= base_init[19:0];
              p_base    <= base_init[31:20];
              n_lay     <= nl_clamp;
              cur_layer <= '0;
`ifdef LAYER_SEQ_TIMEOUT_EN
              err_q     <= 1'b0;
`endif
            end
          end
          LOAD: begin
            layer_config <= {16'b0, ent[8:6], ent[5:1],
                             cur_layer, is_last, ent[0],
                             is_last, is_first};
            base_addr    <= {p_base, w_base};
            state        <= START;
          end
          START: begin
            layer_start <= 1'b1;
            state       <= WAIT;
`ifdef LAYER_SEQ_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
          end
          WAIT: begin
            if (done_edge) begin
              gap_cnt <= '0;
              state   <= (GAP_CYCLES == 0) ? NEXT : GAP;
            end
`ifdef LAYER_SEQ_TIMEOUT_EN
            else if (wait_cnt == TLAST) begin
              err_q <= 1'b1;
              state <= IDLE;
            end else begin
              wait_cnt <= wait_cnt + 24'd1;
            end
`endif
          end
          GAP: begin
            if (gap_cnt == GLAST) state <= NEXT;
            else gap_cnt <= gap_cnt + GW'(1);
          end
          NEXT: begin
            w_base <= w_base + (ent[0] ? W3 : W1);
            p_base <= p_base + PS;
            if (is_last) begin
              state    <= DONE;
              all_done <= 1'b1;
            end else begin
              cur_layer <= cur_layer + 4'd1;
              state     <= LOAD;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
